// File: rtl/padctl_pkg.sv
// Shared pad-control types: strap sequencer states and DPS pad mode encoding.
package padctl_pkg;

    typedef enum logic [1:0] {
        SAMPLE  = 2'd0,
        LOCKED  = 2'd1,
        STRETCH = 2'd2
    } strap_state_e;

    typedef enum logic {
        PadModeJtag = 1'b0,
        PadModeSpi  = 1'b1
    } pad_mode_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchroniser for asynchronous pad inputs with a per-instance reset value.
module prim_flop_2sync #(
    parameter int Width = 1,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] stage1;

    // Two back-to-back flops give metastability a full cycle to resolve.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage1 <= ResetValue;
            q_o    <= ResetValue;
        end else begin
            stage1 <= d_i;
            q_o    <= stage1;
        end
    end

endmodule

// File: rtl/dps_strap_ctrl.sv
// Strap sampler for the shared debug/SPI pads: debounces and locks the mode and
// bootstrap straps, holds the system reset request until locked, and stretches
// external JTAG system resets before re-sampling.
module dps_strap_ctrl
    import padctl_pkg::*;
#(
    parameter int DebounceCycles = 16,
    parameter int StretchCycles  = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic strap_spi_i,
    input  logic strap_boot_i,
    input  logic ext_srst_ni,
    output logic mode_spi_o,
    output logic bootstrap_o,
    output logic mode_valid_o,
    output logic sys_rst_req_o
);

    localparam int CntW = $clog2(max_int(DebounceCycles, StretchCycles));
    localparam logic [CntW-1:0] DebounceLast = CntW'(DebounceCycles - 1);
    localparam logic [CntW-1:0] StretchLast  = CntW'(StretchCycles - 1);

    if (DebounceCycles < 2 || DebounceCycles > 256) begin : gen_debounce_range_chk
        $error("DebounceCycles must be within 2..256");
    end
    if (StretchCycles < 1 || StretchCycles > 256) begin : gen_stretch_range_chk
        $error("StretchCycles must be within 1..256");
    end

    logic spi_sync;
    logic boot_sync;
    logic srst_n_sync;

    prim_flop_2sync #(.Width(1), .ResetValue(1'b0)) u_sync_spi (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (strap_spi_i),
        .q_o   (spi_sync)
    );

    prim_flop_2sync #(.Width(1), .ResetValue(1'b0)) u_sync_boot (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (strap_boot_i),
        .q_o   (boot_sync)
    );

    prim_flop_2sync #(.Width(1), .ResetValue(1'b1)) u_sync_srst (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (ext_srst_ni),
        .q_o   (srst_n_sync)
    );

    strap_state_e    state;
    strap_state_e    state_next;
    logic [CntW-1:0] cnt;
    logic [CntW-1:0] cnt_next;
    logic [1:0]      prev;
    logic [1:0]      prev_next;
    logic [1:0]      straps;
    logic            lock_now;

    assign straps = {spi_sync, boot_sync};

    // Next-state logic; an external reset overrides everything, including a lock.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        prev_next  = prev;
        lock_now   = 1'b0;
        if (!srst_n_sync) begin
            state_next = STRETCH;
            cnt_next   = '0;
        end else begin
            unique case (state)
                SAMPLE: begin
                    if (straps != prev) begin
                        prev_next = straps;
                        cnt_next  = '0;
                    end else if (cnt == DebounceLast) begin
                        state_next = LOCKED;
                        lock_now   = 1'b1;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    state_next = LOCKED;
                end
                STRETCH: begin
                    if (cnt == StretchLast) begin
                        state_next = SAMPLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = SAMPLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // State, counter, strap history and registered output decodes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= SAMPLE;
            cnt           <= '0;
            prev          <= 2'b00;
            mode_spi_o    <= PadModeJtag;
            bootstrap_o   <= 1'b0;
            mode_valid_o  <= 1'b0;
            sys_rst_req_o <= 1'b1;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            prev          <= prev_next;
            mode_valid_o  <= (state_next == LOCKED);
            sys_rst_req_o <= (state_next != LOCKED);
            if (lock_now) begin
                mode_spi_o  <= prev[1];
                bootstrap_o <= prev[0];
            end
        end
    end

    // Locked strap values must never move while they are advertised as valid.
    assert property (@(posedge clk_i) disable iff (rst_i)
        mode_valid_o |=> $stable({mode_spi_o, bootstrap_o}));

endmodule

// File: tb/tb_dps_strap_ctrl.sv
// Testbench for dps_strap_ctrl: directed scenarios with literal edge-exact
// expectations plus randomized pad activity checked against a behavioural model.
module tb_dps_strap_ctrl;

    localparam int Debounce = 16;
    localparam int Stretch  = 8;

    logic clk = 1'b0;
    logic rst;
    logic strap_spi;
    logic strap_boot;
    logic ext_srst_n;
    logic mode_spi;
    logic bootstrap;
    logic mode_valid;
    logic sys_rst_req;

    int checks   = 0;
    int failures = 0;

    dps_strap_ctrl #(.DebounceCycles(Debounce), .StretchCycles(Stretch)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .strap_spi_i   (strap_spi),
        .strap_boot_i  (strap_boot),
        .ext_srst_ni   (ext_srst_n),
        .mode_spi_o    (mode_spi),
        .bootstrap_o   (bootstrap),
        .mode_valid_o  (mode_valid),
        .sys_rst_req_o (sys_rst_req)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Behavioural model: pad pipelines, a run length of identical strap
    // samples and a count of released-reset cycles decide the outputs.
    logic m_sp1 = 1'b0, m_sp2 = 1'b0;
    logic m_bt1 = 1'b0, m_bt2 = 1'b0;
    logic m_sr1 = 1'b1, m_sr2 = 1'b1;
    logic [1:0] m_last = 2'b00;
    int   m_run = 0;
    int   m_high_run = 0;
    logic m_locked = 1'b0;
    logic m_stretching = 1'b0;
    logic m_spi = 1'b0;
    logic m_boot = 1'b0;

    // Model update on each clock, reset immediately with rst.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sp1 = 1'b0; m_sp2 = 1'b0;
            m_bt1 = 1'b0; m_bt2 = 1'b0;
            m_sr1 = 1'b1; m_sr2 = 1'b1;
            m_last = 2'b00;
            m_run = 0;
            m_high_run = 0;
            m_locked = 1'b0;
            m_stretching = 1'b0;
            m_spi = 1'b0;
            m_boot = 1'b0;
        end else begin
            if (!m_sr2) begin
                m_stretching = 1'b1;
                m_locked = 1'b0;
                m_high_run = 0;
            end else if (m_stretching) begin
                m_high_run = m_high_run + 1;
                if (m_high_run == Stretch) begin
                    m_stretching = 1'b0;
                    m_run = 0;
                end
            end else if (!m_locked) begin
                if ({m_sp2, m_bt2} != m_last) begin
                    m_last = {m_sp2, m_bt2};
                    m_run = 0;
                end else begin
                    m_run = m_run + 1;
                    if (m_run == Debounce) begin
                        m_locked = 1'b1;
                        m_spi = m_last[1];
                        m_boot = m_last[0];
                    end
                end
            end
            m_sp2 = m_sp1; m_sp1 = strap_spi;
            m_bt2 = m_bt1; m_bt1 = strap_boot;
            m_sr2 = m_sr1; m_sr1 = ext_srst_n;
        end
    end

    task automatic check_output(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every cycle, 3 units after the rising edge.
    always @(posedge clk) begin
        #3;
        check_output("model_mode_valid", mode_valid, m_locked);
        check_output("model_sys_rst_req", sys_rst_req, !m_locked);
        check_output("model_mode_spi", mode_spi, m_spi);
        check_output("model_bootstrap", bootstrap, m_boot);
    end

    task automatic apply_stimulus(input logic spi, input logic boot, input logic srst_n);
        @(negedge clk);
        strap_spi  = spi;
        strap_boot = boot;
        ext_srst_n = srst_n;
    endtask

    task automatic apply_reset(input logic spi, input logic boot);
        @(negedge clk);
        rst        = 1'b1;
        strap_spi  = spi;
        strap_boot = boot;
        ext_srst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int srst_left;

    // Directed scenarios followed by randomized pad activity.
    initial begin
        rst        = 1'b1;
        strap_spi  = 1'b0;
        strap_boot = 1'b0;
        ext_srst_n = 1'b1;

        // Reset state.
        wait_edges(1);
        check_output("reset_valid", mode_valid, 1'b0);
        check_output("reset_req", sys_rst_req, 1'b1);

        // Straps at 0: lock on edge 16.
        apply_reset(1'b0, 1'b0);
        wait_edges(15);
        check_output("zero_valid_e15", mode_valid, 1'b0);
        check_output("zero_req_e15", sys_rst_req, 1'b1);
        wait_edges(1);
        check_output("zero_valid_e16", mode_valid, 1'b1);
        check_output("zero_req_e16", sys_rst_req, 1'b0);
        check_output("zero_spi", mode_spi, 1'b0);
        check_output("zero_boot", bootstrap, 1'b0);

        // Straps at 1/1: lock on edge 19.
        apply_reset(1'b1, 1'b1);
        wait_edges(18);
        check_output("ones_valid_e18", mode_valid, 1'b0);
        wait_edges(1);
        check_output("ones_valid_e19", mode_valid, 1'b1);
        check_output("ones_spi", mode_spi, 1'b1);
        check_output("ones_boot", bootstrap, 1'b1);

        // SPI strap with a one-cycle glitch at edge 10: lock moves to edge 29.
        apply_reset(1'b1, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        strap_spi = 1'b0;
        @(posedge clk);
        @(negedge clk);
        strap_spi = 1'b1;
        wait_edges(18);
        check_output("glitch_valid_e28", mode_valid, 1'b0);
        wait_edges(1);
        check_output("glitch_valid_e29", mode_valid, 1'b1);
        check_output("glitch_spi", mode_spi, 1'b1);

        // Strap toggling after lock is ignored.
        repeat (4) begin
            @(negedge clk);
            strap_spi = ~strap_spi;
        end
        apply_stimulus(1'b0, 1'b0, 1'b1);
        wait_edges(5);
        check_output("locked_toggle_spi", mode_spi, 1'b1);
        check_output("locked_toggle_valid", mode_valid, 1'b1);

        // External reset low for 5 cycles, then stretch and re-lock with SPI=0.
        apply_stimulus(1'b0, 1'b0, 1'b0);
        wait_edges(2);
        check_output("srst_req_e2", sys_rst_req, 1'b0);
        wait_edges(1);
        check_output("srst_req_e3", sys_rst_req, 1'b1);
        check_output("srst_valid_e3", mode_valid, 1'b0);
        check_output("srst_spi_held", mode_spi, 1'b1);
        repeat (2) @(posedge clk);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        wait_edges(9);
        check_output("stretch_req_e14", sys_rst_req, 1'b1);
        wait_edges(1);
        check_output("stretch_req_e15", sys_rst_req, 1'b1);
        wait_edges(16);
        check_output("relock_valid_e31", mode_valid, 1'b0);
        wait_edges(1);
        check_output("relock_valid_e32", mode_valid, 1'b1);
        check_output("relock_spi", mode_spi, 1'b0);

        // rst asserted mid-stretch: immediate reset values, then full debounce.
        apply_reset(1'b1, 1'b1);
        wait_edges(19);
        check_output("pre_rst_spi", mode_spi, 1'b1);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        wait_edges(5);
        check_output("mid_stretch_req", sys_rst_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_output("async_rst_valid", mode_valid, 1'b0);
        check_output("async_rst_req", sys_rst_req, 1'b1);
        check_output("async_rst_spi", mode_spi, 1'b0);
        check_output("async_rst_boot", bootstrap, 1'b0);
        @(negedge clk);
        ext_srst_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_edges(18);
        check_output("rerun_valid_e18", mode_valid, 1'b0);
        wait_edges(1);
        check_output("rerun_valid_e19", mode_valid, 1'b1);
        check_output("rerun_spi", mode_spi, 1'b1);

        // Randomized pad activity against the model.
        srst_left = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 799) == 0) rst = 1'b1;
            if ($urandom_range(0, 19) == 0) strap_spi = ~strap_spi;
            if ($urandom_range(0, 29) == 0) strap_boot = ~strap_boot;
            if (srst_left > 0) begin
                srst_left--;
                if (srst_left == 0) ext_srst_n = 1'b1;
            end else if ($urandom_range(0, 149) == 0) begin
                ext_srst_n = 1'b0;
                srst_left = int'($urandom_range(1, 12));
            end
        end

        wait_edges(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dps_strap_ctrl.md
# dps_strap_ctrl

Strap-sampling and pad-mode sequencer for the FPGA top's shared debug/SPI pad group. It synchronises and debounces the mode strap (JTAG vs SPI device on the DPS pads) and the bootstrap strap, then locks both. It holds the system reset request asserted until the straps are locked. On every external JTAG system reset it stretches the reset and re-samples the straps. It sits between the raw pads and the pad controller mux and clock/reset generator.

## Interface
- DebounceCycles, 16: consecutive stable synchronised cycles required to lock the straps; legal range 2..256.
- StretchCycles, 8: minimum cycles the reset request stays asserted after the external system reset releases; legal range 1..256.

- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- strap_spi_i  in  1  raw mode strap pad (1 = SPI device, 0 = JTAG); asynchronous
- strap_boot_i  in  1  raw bootstrap strap pad; asynchronous
- ext_srst_ni  in  1  raw JTAG system reset pad, active-low; asynchronous
- mode_spi_o  out  1  locked pad mode; selects spi_device routing when 1
- bootstrap_o  out  1  locked bootstrap strap
- mode_valid_o  out  1  straps locked; the outputs above are meaningful
- sys_rst_req_o  out  1  active-high reset request to the clock/reset generator

## Operation
- Inputs pass through 2-flop synchronisers.
  - Strap synchronisers reset to 0.
  - The ext_srst_ni synchroniser resets to 1 (deasserted).
- State machine has three states: SAMPLE (reset state), LOCKED, STRETCH.
- One counter, cnt, with width $clog2(max(DebounceCycles, StretchCycles)), and one 2-bit register, prev = {spi, boot}, reset to 0.
- SAMPLE:
  - If the synchronised straps differ from prev: load prev with them and clear cnt.
  - Else if cnt == DebounceCycles-1: go to LOCKED and latch prev into mode_spi_o / bootstrap_o.
  - Else increment cnt.
- LOCKED:
  - Straps are ignored; mode_spi_o and bootstrap_o are frozen.
  - mode_valid_o = 1, sys_rst_req_o = 0.
- STRETCH:
  - Entered from any state when synchronised srst_n = 0. This takes priority over a lock in the same cycle.
  - While srst_n is low, cnt is held at 0.
  - Once srst_n is high, cnt counts up. At cnt == StretchCycles-1 the FSM goes to SAMPLE with cnt = 0; prev is kept.
  - srst_n going low again during the count clears cnt.
- Outputs:
  - mode_valid_o = (state == LOCKED); sys_rst_req_o = !mode_valid_o. Both are registered state decodes.
  - mode_spi_o and bootstrap_o keep their last locked value outside LOCKED. Consumers qualify them with mode_valid_o.
- Reset values: mode_spi_o = 0 (JTAG default), bootstrap_o = 0, mode_valid_o = 0, sys_rst_req_o = 1.

## Timing
- Synchroniser latency is 2 cycles on every input.
- Straps stable at 0 from reset release: LOCKED is registered at the DebounceCycles-th rising edge (edge 16 with defaults).
- Straps stable with any bit at 1 from reset release:
  - One edge is spent on the prev update.
  - LOCKED is registered at edge DebounceCycles+3 (edge 19).
- A strap glitch of any width before lock restarts the debounce window. A glitch after lock has no effect.
- External reset release to SAMPLE: 2 synchroniser cycles plus StretchCycles edges. Re-lock then follows the debounce rules from the current prev.
- rst_i asserted mid-operation: all state returns asynchronously to reset values; sys_rst_req_o = 1 immediately.
- An ext_srst_ni pulse shorter than 2 cycles may be missed; this is by design and is not flagged.

## Structure
- Shared package padctl_pkg holds:
  - strap_state_e {SAMPLE, LOCKED, STRETCH}
  - the pad_mode_e {PadModeJtag = 0, PadModeSpi = 1} encoding
- Synchronisers are instantiated as three prim_flop_2sync instances with per-instance ResetValue. No other sub-module is used.
- Parameter range checks are elaboration-time assertions. An SVA checks that mode_spi_o and bootstrap_o are stable while mode_valid_o = 1.

## Test plan
All scenarios use the default parameters.

- Reset release, both straps held at 0:
  - mode_valid_o rises and sys_rst_req_o falls at edge 16.
  - mode_spi_o = 0, bootstrap_o = 0.
- Reset release, strap_spi_i = 1, strap_boot_i = 1:
  - Lock at edge 19.
  - mode_spi_o = 1, bootstrap_o = 1.
- strap_spi_i = 1 with a 1-cycle 0 glitch at edge 10:
  - Lock is delayed until 16 stable cycles after the glitch.
  - Final mode_spi_o = 1.
- After lock, change strap_spi_i to 0, then pulse ext_srst_ni low for 5 cycles:
  - sys_rst_req_o = 1 from 2 cycles after the falling edge.
  - The output stays asserted through 8 cycles after release, then re-locks with mode_spi_o = 0.
- Toggle strap_spi_i after lock with no external reset:
  - mode_spi_o is unchanged and mode_valid_o stays 1.
- Assert rst_i mid-STRETCH:
  - Outputs go immediately to reset values.
  - After rst_i deasserts, the full debounce sequence runs again.
